// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-type constants,
// common to the transmit and receive paths.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/serializer.sv
// LSB-first shift register with a bounded bit counter; done_o flags that the
// bit currently on the line is the last payload bit.
module serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  shift_en_i,
   output logic                  bit_o,
   output logic                  done_o
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   assign done_o = (cnt_q == CNT_W'(DATA_WIDTH - 1));

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shift_d = data_i;
         cnt_d   = '0;
      end else if (shift_en_i && !done_o) begin
         shift_d = shift_q >> 1;
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   // Look-ahead: the bit that will be on the line after this edge.
   assign bit_o = shift_d[0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit,
// with back-to-back frames accepted during the stop bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  BUSY
);

   uart_state_e           state_q, state_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  load;
   logic                  shift_en;
   logic                  ser_bit;
   logic                  ser_done;

   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                       input logic                  typ);
      return (^data) ^ (typ == PAR_ODD);
   endfunction

   assign load     = DATA_VALID && ((state_q == IDLE) || (state_q == STOP));
   assign shift_en = (state_q == DATA);

   serializer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_serializer (
      .clk_i     (CLK),
      .rst_i     (RST),
      .load_i    (load),
      .data_i    (P_DATA),
      .shift_en_i(shift_en),
      .bit_o     (ser_bit),
      .done_o    (ser_done)
   );

   // Outputs are computed for the state being entered so TX_OUT/BUSY change on the same edge.
   always_comb begin
      state_d = state_q;
      tx_d    = 1'b1;
      busy_d  = 1'b1;
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (DATA_VALID) begin
               state_d = START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            state_d = DATA;
            tx_d    = ser_bit;
         end
         DATA: begin
            if (ser_done) begin
               if (par_en_q) begin
                  state_d = PARITY;
                  tx_d    = parity_bit(data_q, par_typ_q);
               end else begin
                  state_d = STOP;
               end
            end else begin
               tx_d = ser_bit;
            end
         end
         PARITY: state_d = STOP;
         STOP: begin
            if (DATA_VALID) begin
               state_d = START;
               tx_d    = 1'b0;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= PAR_EVEN;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         if (load) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
         end
      end
   end

   assign TX_OUT = tx_q;
   assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: table-driven frames plus hand-written back-to-back,
// mid-frame request, mid-frame reset and reset-priority sequences.
module tb_uart_tx;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST;
   logic [W-1:0] P_DATA;
   logic         DATA_VALID;
   logic         PAR_EN;
   logic         PAR_TYP;
   logic         TX_OUT;
   logic         BUSY;

   always #5 CLK = ~CLK;

   uart_tx #(.DATA_WIDTH(W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .P_DATA    (P_DATA),
      .DATA_VALID(DATA_VALID),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .TX_OUT    (TX_OUT),
      .BUSY      (BUSY)
   );

   typedef struct {
      logic tx;
      logic busy;
      int   tag;
   } exp_t;

   typedef struct {
      logic [W-1:0] d;
      logic         pe;
      logic         pt;
      logic         par;
      int           len;
   } vec_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;
   int   tag_n  = 0;

   // One expected {TX_OUT, BUSY} pair per rising edge, sampled 1 time unit later.
   always @(posedge CLK) begin : monitor
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (TX_OUT === e.tx) passes++;
         else $display("FAIL tx_out step %0d: got %b expected %b", e.tag, TX_OUT, e.tx);
         checks++;
         if (BUSY === e.busy) passes++;
         else $display("FAIL busy step %0d: got %b expected %b", e.tag, BUSY, e.busy);
      end
   end

   task automatic push(input logic tx, input logic busy);
      exp_t e;
      e.tx   = tx;
      e.busy = busy;
      e.tag  = tag_n;
      tag_n++;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic par,
                             input int limit);
      logic b[$];
      b.push_back(1'b0);
      for (int i = 0; i < W; i++) b.push_back(d[i]);
      if (pe) b.push_back(par);
      b.push_back(1'b1);
      for (int i = 0; i < b.size() && i < limit; i++) push(b[i], 1'b1);
   endtask

   // Called just after a falling edge; returns one falling edge later.
   task automatic start_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                              input logic par, input int limit);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      DATA_VALID = 1'b1;
      push_frame(d, pe, par, limit);
      @(negedge CLK);
      DATA_VALID = 1'b0;
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         push(1'b1, 1'b0);
         @(negedge CLK);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
      $fatal(1);
   end

   initial begin : stim
      vec_t vecs[8];
      vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10};
      vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11};
      vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 11};
      vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 11};
      vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 11};
      vecs[5] = '{8'h7F, 1'b1, 1'b0, 1'b1, 11};
      vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 11};
      vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b0, 10};

      RST        = 1'b1;
      DATA_VALID = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      P_DATA     = '0;
      @(negedge CLK);
      push(1'b1, 1'b0);
      @(negedge CLK);
      RST = 1'b0;
      idle(2);

      for (int v = 0; v < 8; v++) begin
         start_frame(vecs[v].d, vecs[v].pe, vecs[v].pt, vecs[v].par, 99);
         wait_neg(vecs[v].len - 1);
         idle(1);
      end

      // Back-to-back: second request issued during the first frame's stop bit.
      start_frame(8'h3C, 1'b0, 1'b0, 1'b0, 99);
      wait_neg(9);
      start_frame(8'hFF, 1'b1, 1'b1, 1'b1, 99);
      wait_neg(10);
      idle(2);

      // Request during data bit 3 must be ignored.
      start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 99);
      wait_neg(4);
      P_DATA     = 8'h00;
      PAR_EN     = 1'b1;
      DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
      wait_neg(4);
      idle(3);

      // Reset while data bit 4 is on the line, then a fresh frame.
      start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 6);
      wait_neg(5);
      RST = 1'b1;
      push(1'b1, 1'b0);
      @(negedge CLK);
      RST = 1'b0;
      idle(2);
      start_frame(8'h81, 1'b1, 1'b0, 1'b0, 99);
      wait_neg(10);
      idle(2);

      // Reset wins over a simultaneous request.
      RST        = 1'b1;
      DATA_VALID = 1'b1;
      P_DATA     = 8'h55;
      push(1'b1, 1'b0);
      @(negedge CLK);
      RST        = 1'b0;
      DATA_VALID = 1'b0;
      idle(3);

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
